spbram_arbiter: RTL and testbench

Two-port front end for the single-port block RAM: arbitrates between two requesters (m0, m1) with round-robin fairness and optional locked bursts, drives the RAM's one address/enable/write port with registered signals, and routes read data back to the issuing requester. Sits between the RAM and its users, for example a pixel writer and a pixel reader sharing one frame buffer.

---
 rtl/spbram_arbiter.sv | 148 ++++++++++++++
 tb/tb_spbram_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spbram_arbiter.sv
// Round-robin two-requester front end for a single-port block RAM with locked bursts,
// registered RAM port and a 2-stage read-return pipeline routing data back to the issuer.
module spbram_arbiter #(
  parameter int unsigned DWIDTH   = 16,
  parameter int unsigned AWIDTH   = 12,
  parameter int unsigned MEM_SIZE = 3840
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [DWIDTH-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_rvalid,
  output logic [DWIDTH-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_rvalid,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_d,
  input  logic [DWIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;  // 1: m1 was granted last

  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_d_q, mem_d_d;

  logic s1_rd_q, s1_rd_d, s1_err_q, s1_err_d, s1_own_q, s1_own_d;
  logic s2_rd_q, s2_err_q, s2_own_q;

  logic              gnt0, gnt1, acc, sel, in_range;
  logic              b_we, b_lock;
  logic [AWIDTH-1:0] b_addr;
  logic [DWIDTH-1:0] b_wdata;

  // Grant; ready is suppressed during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          if (m0_req && m1_req) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        StOwn0:  gnt0 = m0_req;
        StOwn1:  gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  assign m0_ready = gnt0;
  assign m1_ready = gnt1;
  assign acc      = gnt0 | gnt1;
  assign sel      = gnt1;
  assign b_we     = sel ? m1_we    : m0_we;
  assign b_lock   = sel ? m1_lock  : m0_lock;
  assign b_addr   = sel ? m1_addr  : m0_addr;
  assign b_wdata  = sel ? m1_wdata : m0_wdata;
  assign in_range = 32'(b_addr) < MEM_SIZE;

  always_comb begin
    state_d = state_q;
    last_d  = acc ? sel : last_q;
    unique case (state_q)
      StIdle: if (acc && b_lock) state_d = sel ? StOwn1 : StOwn0;
      StOwn0, StOwn1: if (acc && !b_lock) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_ce_d   = acc && in_range;
    mem_we_d   = acc && in_range && b_we;
    mem_addr_d = (acc && in_range) ? b_addr  : mem_addr_q;
    mem_d_d    = (acc && in_range) ? b_wdata : mem_d_q;
    s1_rd_d    = acc && !b_we;
    s1_err_d   = acc && !in_range;
    s1_own_d   = sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
      s1_rd_q    <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_own_q   <= 1'b0;
      s2_rd_q    <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_own_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      mem_ce_q   <= mem_ce_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      s1_rd_q    <= s1_rd_d;
      s1_err_q   <= s1_err_d;
      s1_own_q   <= s1_own_d;
      s2_rd_q    <= s1_rd_q;
      s2_err_q   <= s1_err_q;
      s2_own_q   <= s1_own_q;
    end
  end

  assign mem_ce   = mem_ce_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_d    = mem_d_q;

  // Out-of-range reads return zero instead of whatever mem_q holds.
  assign m0_rvalid = s2_rd_q && !s2_own_q;
  assign m1_rvalid = s2_rd_q && s2_own_q;
  assign m0_err    = s2_err_q && !s2_own_q;
  assign m1_err    = s2_err_q && s2_own_q;
  assign m0_rdata  = (m0_rvalid && !s2_err_q) ? mem_q : '0;
  assign m1_rdata  = (m1_rvalid && !s2_err_q) ? mem_q : '0;

endmodule

// File: tb/tb_spbram_arbiter.sv
// Self-checking bench for spbram_arbiter: vector table for grants/RAM strobes, scoreboard for
// read returns and error pulses, plus lock-burst and reset-mid-read sequences.
module tb_spbram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [11:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_ready, m0_rvalid, m0_err, m1_ready, m1_rvalid, m1_err;
  logic [15:0] m0_rdata, m1_rdata;
  logic        mem_ce, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_d, mem_q;

  spbram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Read-first single-port RAM with one-cycle read latency.
  logic [15:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_d;
      mem_q <= ram[mem_addr];
    end
  end

  typedef struct {
    int          due;
    logic        rv;
    logic [15:0] d;
    logic        err;
  } exp_t;

  typedef struct {
    logic        r0, w0, l0;
    logic [11:0] a0;
    logic [15:0] d0;
    logic        r1, w1, l1;
    logic [11:0] a1;
    logic [15:0] d1;
    logic        e0, e1, ece, ewe;
  } vec_t;

  exp_t        q0[$], q1[$];
  logic [15:0] shadow [0:4095];
  vec_t        vt [27];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic set0(logic r, logic w, logic l, logic [11:0] a, logic [15:0] d);
    m0_req = r; m0_we = w; m0_lock = l; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(logic r, logic w, logic l, logic [11:0] a, logic [15:0] d);
    m1_req = r; m1_we = w; m1_lock = l; m1_addr = a; m1_wdata = d;
  endtask

  task automatic accept(int p, logic we, logic [11:0] a, logic [15:0] d);
    exp_t e;
    e.due = cyc + 2; e.rv = 1'b0; e.d = '0; e.err = 1'b0;
    if (a >= 12'd3840) begin
      e.err = 1'b1;
      e.rv  = !we;
    end else if (we) begin
      shadow[a] = d;
      return;
    end else begin
      e.rv = 1'b1;
      e.d  = shadow[a];
    end
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon(int p, logic rv, logic [15:0] rd, logic er);
    exp_t e;
    e.due = 0; e.rv = 1'b0; e.d = '0; e.err = 1'b0;
    if (p == 0 && q0.size() > 0 && q0[0].due == cyc) e = q0.pop_front();
    if (p == 1 && q1.size() > 0 && q1[0].due == cyc) e = q1.pop_front();
    chk($sformatf("m%0d_rvalid", p), 32'(rv), 32'(e.rv));
    chk($sformatf("m%0d_rdata", p), 32'(rd), 32'(e.d));
    chk($sformatf("m%0d_err", p), 32'(er), 32'(e.err));
  endtask

  task automatic sample();
    @(negedge clk);
    mon(0, m0_rvalid, m0_rdata, m0_err);
    mon(1, m1_rvalid, m1_rdata, m1_err);
    if (m0_req && m0_ready) accept(0, m0_we, m0_addr, m0_wdata);
    if (m1_req && m1_ready) accept(1, m1_we, m1_addr, m1_wdata);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_rdy(string n, logic e0, logic e1);
    sample();
    chk({n, " m0_ready"}, 32'(m0_ready), 32'(e0));
    chk({n, " m1_ready"}, 32'(m1_ready), 32'(e1));
    advance();
  endtask

  function automatic vec_t mk(logic r0, logic w0, logic [11:0] a0, logic [15:0] d0,
                              logic r1, logic w1, logic [11:0] a1, logic [15:0] d1,
                              logic e0, logic e1, logic ece, logic ewe);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = 1'b0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = 1'b0; v.a1 = a1; v.d1 = d1;
    v.e0 = e0; v.e1 = e1; v.ece = ece; v.ewe = ewe;
    return v;
  endfunction

  initial begin
    // single requester write then read
    vt[0]  = mk(1, 1, 12'd5, 16'hBEEF, 0, 0, 12'd0, 16'h0, 1, 0, 0, 0);
    vt[1]  = mk(1, 0, 12'd5, 16'h0, 0, 0, 12'd0, 16'h0, 1, 0, 1, 1);
    vt[2]  = mk(0, 0, 12'd0, 16'h0, 0, 0, 12'd0, 16'h0, 0, 0, 1, 0);
    vt[3]  = mk(0, 0, 12'd0, 16'h0, 0, 0, 12'd0, 16'h0, 0, 0, 0, 0);
    // preload 10 and 20, leaving m1 as last grantee
    vt[4]  = mk(1, 1, 12'd10, 16'h1111, 0, 0, 12'd0, 16'h0, 1, 0, 0, 0);
    vt[5]  = mk(0, 0, 12'd0, 16'h0, 1, 1, 12'd20, 16'h2222, 0, 1, 1, 1);
    // contention: both read every cycle, grants alternate starting at m0
    for (int i = 0; i < 8; i++)
      vt[6+i] = mk(1, 0, 12'd10, 16'h0, 1, 0, 12'd20, 16'h0, (i % 2) == 0, (i % 2) == 1,
                   1, i == 0);
    // out of range read and write
    vt[14] = mk(1, 0, 12'd3840, 16'h0, 0, 0, 12'd0, 16'h0, 1, 0, 1, 0);
    vt[15] = mk(1, 1, 12'd4000, 16'h7777, 0, 0, 12'd0, 16'h0, 1, 0, 0, 0);
    vt[16] = mk(0, 0, 12'd0, 16'h0, 0, 0, 12'd0, 16'h0, 0, 0, 0, 0);
    vt[17] = mk(0, 0, 12'd0, 16'h0, 0, 0, 12'd0, 16'h0, 0, 0, 0, 0);
    // read then write same address: old data, then new
    vt[18] = mk(0, 0, 12'd0, 16'h0, 1, 0, 12'd20, 16'h0, 0, 1, 0, 0);
    vt[19] = mk(0, 0, 12'd0, 16'h0, 1, 1, 12'd20, 16'h3333, 0, 1, 1, 0);
    vt[20] = mk(0, 0, 12'd0, 16'h0, 1, 0, 12'd20, 16'h0, 0, 1, 1, 1);
    vt[21] = mk(0, 0, 12'd0, 16'h0, 0, 0, 12'd0, 16'h0, 0, 0, 1, 0);
    vt[22] = mk(0, 0, 12'd0, 16'h0, 0, 0, 12'd0, 16'h0, 0, 0, 0, 0);
    // last valid address
    vt[23] = mk(1, 1, 12'd3839, 16'hA5A5, 0, 0, 12'd0, 16'h0, 1, 0, 0, 0);
    vt[24] = mk(1, 0, 12'd3839, 16'h0, 0, 0, 12'd0, 16'h0, 1, 0, 1, 1);
    vt[25] = mk(0, 0, 12'd0, 16'h0, 0, 0, 12'd0, 16'h0, 0, 0, 1, 0);
    vt[26] = mk(0, 0, 12'd0, 16'h0, 0, 0, 12'd0, 16'h0, 0, 0, 0, 0);

    rst_n = 1'b0;
    set0(1, 0, 0, 12'd0, 16'h0);
    set1(1, 0, 0, 12'd0, 16'h0);
    #12;
    chk("rst m0_ready", 32'(m0_ready), 0);
    chk("rst m1_ready", 32'(m1_ready), 0);
    chk("rst mem_ce", 32'(mem_ce), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst mem_d", 32'(mem_d), 0);
    chk("rst m0_rvalid", 32'(m0_rvalid), 0);
    chk("rst m1_err", 32'(m1_err), 0);
    set0(0, 0, 0, 12'd0, 16'h0);
    set1(0, 0, 0, 12'd0, 16'h0);
    advance();
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      set0(vt[i].r0, vt[i].w0, vt[i].l0, vt[i].a0, vt[i].d0);
      set1(vt[i].r1, vt[i].w1, vt[i].l1, vt[i].a1, vt[i].d1);
      sample();
      chk($sformatf("v%0d m0_ready", i), 32'(m0_ready), 32'(vt[i].e0));
      chk($sformatf("v%0d m1_ready", i), 32'(m1_ready), 32'(vt[i].e1));
      chk($sformatf("v%0d mem_ce", i), 32'(mem_ce), 32'(vt[i].ece));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vt[i].ewe));
      advance();
    end

    // lock burst by m1 while m0 requests continuously (m0 was last, so m1 wins the tie)
    set0(1, 0, 0, 12'd10, 16'h0);
    set1(1, 1, 1, 12'd100, 16'hC000);
    step_rdy("lock0", 0, 1);
    set1(1, 1, 1, 12'd101, 16'hC001);
    step_rdy("lock1", 0, 1);
    set1(0, 0, 0, 12'd0, 16'h0);
    step_rdy("lock idle owner", 0, 0);
    set1(1, 1, 1, 12'd102, 16'hC002);
    step_rdy("lock2", 0, 1);
    set1(1, 1, 0, 12'd103, 16'hC003);
    step_rdy("lock3 release", 0, 1);
    set1(1, 0, 0, 12'd100, 16'h0);
    step_rdy("post release", 1, 0);
    set0(0, 0, 0, 12'd0, 16'h0);
    step_rdy("m1 follows", 0, 1);
    set1(0, 0, 0, 12'd0, 16'h0);
    for (int i = 0; i < 3; i++) step_rdy("drain", 0, 0);

    // reset one cycle after a read is accepted
    set0(1, 0, 0, 12'd5, 16'h0);
    step_rdy("pre-reset read", 1, 0);
    set0(1, 0, 0, 12'd20, 16'h0);
    set1(1, 0, 0, 12'd5, 16'h0);
    rst_n = 1'b0;
    #1;
    chk("mid rst mem_ce", 32'(mem_ce), 0);
    chk("mid rst mem_addr", 32'(mem_addr), 0);
    chk("mid rst m0_ready", 32'(m0_ready), 0);
    chk("mid rst m0_rvalid", 32'(m0_rvalid), 0);
    q0.delete();
    q1.delete();
    step_rdy("in reset", 0, 0);
    step_rdy("in reset", 0, 0);
    rst_n = 1'b1;
    step_rdy("tie after reset", 1, 0);
    set0(0, 0, 0, 12'd0, 16'h0);
    step_rdy("m1 after tie", 0, 1);
    set1(0, 0, 0, 12'd0, 16'h0);
    for (int i = 0; i < 3; i++) step_rdy("final drain", 0, 0);

    chk("m0 queue empty", 32'(q0.size()), 0);
    chk("m1 queue empty", 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
